// File: rtl/countdown_timer_if.sv
// Keypad/control inputs and BCD display/status outputs of the cook timer.
// Latency: n/a (signal bundle only).
// Backpressure: none; all inputs are strobes or levels sampled every cycle.
interface countdown_timer_if;
    logic       digit_valid;
    logic [3:0] digit;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       done;

    // Driver side: keypad and controller requests in, display/status out.
    modport master (
        output digit_valid, digit, start, stop, door_closed,
        input  min, sec_tens, sec_ones, running, done
    );

    // Timer side.
    modport slave (
        input  digit_valid, digit, start, stop, door_closed,
        output min, sec_tens, sec_ones, running, done
    );
endinterface

// File: rtl/countdown_timer.sv
// BCD cook-time register with keypad shift entry and once-per-second countdown.
// Latency: every output registered; digit entry visible one cycle after its strobe.
// Backpressure: none; digit strobes outside IDLE are dropped, stop/door pause RUN.
module countdown_timer #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  bus
);

    localparam int PW = (TICKS_PER_SEC <= 2) ? 1 : $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_nxt;
    logic [3:0]    min_q, tens_q, ones_q;
    logic [3:0]    min_nxt, tens_nxt, ones_nxt;
    logic [PW-1:0] presc_q, presc_nxt;
    logic          running_q, running_nxt;
    logic          done_q, done_nxt;

    logic [3:0]    dec_min, dec_tens, dec_ones;
    logic          time_nz;
    logic          dec_zero;

    assign time_nz  = (min_q != 4'd0) || (tens_q != 4'd0) || (ones_q != 4'd0);
    assign dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);

    // One-second BCD borrow chain; sec_tens above 5 simply counts down from where it is.
    always_comb begin
        dec_min  = min_q;
        dec_tens = tens_q;
        dec_ones = ones_q;
        if (ones_q != 4'd0) begin
            dec_ones = ones_q - 4'd1;
        end else if (tens_q != 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = tens_q - 4'd1;
        end else begin
            dec_ones = 4'd9;
            dec_tens = 4'd5;
            dec_min  = min_q - 4'd1;
        end
    end

    // Next-state, time, prescaler and status; priority stop > door open > tick > start.
    always_comb begin
        state_nxt = state_q;
        min_nxt   = min_q;
        tens_nxt  = tens_q;
        ones_nxt  = ones_q;
        presc_nxt = presc_q;
        done_nxt  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.stop) begin
                    min_nxt  = 4'd0;
                    tens_nxt = 4'd0;
                    ones_nxt = 4'd0;
                end else if (bus.start && bus.door_closed && time_nz) begin
                    state_nxt = RUN;
                    presc_nxt = '0;
                end else if (bus.digit_valid && (bus.digit <= 4'd9)) begin
                    min_nxt  = tens_q;
                    tens_nxt = ones_q;
                    ones_nxt = bus.digit;
                end
            end
            RUN: begin
                if (bus.stop || !bus.door_closed) begin
                    // Prescaler is held so a resume finishes the partial second.
                    state_nxt = PAUSE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_nxt = '0;
                    min_nxt   = dec_min;
                    tens_nxt  = dec_tens;
                    ones_nxt  = dec_ones;
                    if (dec_zero) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    presc_nxt = presc_q + 1'b1;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                    min_nxt   = 4'd0;
                    tens_nxt  = 4'd0;
                    ones_nxt  = 4'd0;
                end else if (bus.start && bus.door_closed) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        running_nxt = (state_nxt == RUN);
    end

    // State, time digits, prescaler and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            min_q     <= 4'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            min_q     <= min_nxt;
            tens_q    <= tens_nxt;
            ones_q    <= ones_nxt;
            presc_q   <= presc_nxt;
            running_q <= running_nxt;
            done_q    <= done_nxt;
        end
    end

    assign bus.min      = min_q;
    assign bus.sec_tens = tens_q;
    assign bus.sec_ones = ones_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed vector table plus hand-written multi-cycle sequences for countdown_timer.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: none; waits on done are bounded by a cycle budget.
module tb_countdown_timer;

    localparam int TPS = 4;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    countdown_timer_if bus ();

    countdown_timer #(.TICKS_PER_SEC(TPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [3:0] d;
        logic       st;
        logic       sp;
        logic       dr;
        logic [3:0] e_min;
        logic [3:0] e_tens;
        logic [3:0] e_ones;
        logic       e_run;
        logic       e_done;
    } vec_t;

    vec_t vecs [17];

    task automatic drive(input logic dv, input logic [3:0] d, input logic st,
                         input logic sp, input logic dr);
        bus.digit_valid = dv;
        bus.digit       = d;
        bus.start       = st;
        bus.stop        = sp;
        bus.door_closed = dr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares {min, sec_tens, sec_ones, running, done} against an expected bundle.
    task automatic check(input string name, input logic [3:0] e_min, input logic [3:0] e_tens,
                         input logic [3:0] e_ones, input logic e_run, input logic e_done);
        logic [13:0] act;
        logic [13:0] exp;
        act = {bus.min, bus.sec_tens, bus.sec_ones, bus.running, bus.done};
        exp = {e_min, e_tens, e_ones, e_run, e_done};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got min=%h tens=%h ones=%h run=%b done=%b, want min=%h tens=%h ones=%h run=%b done=%b",
                     name, act[13:10], act[9:6], act[5:2], act[1], act[0],
                     e_min, e_tens, e_ones, e_run, e_done);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Idles with the door closed until done pulses; returns cycles taken (-1 on timeout).
    task automatic wait_done(output int cycles);
        cycles = -1;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 200; i++) begin
            step();
            if (bus.done === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic enter(input logic [3:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        #1;
    endtask

    initial begin
        int cyc;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        //             dv    d      st    sp    dr    min   tens  ones  run   done
        vecs[0]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd3, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd3, 4'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 4'd1, 4'd3, 4'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd1, 4'd1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0};

        // Reset state, checked before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("reset_state", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        #5 reset = 1'b0;

        // Entry, invalid digit, stop priority, zero-time start, start and first two seconds.
        foreach (vecs[i]) begin
            drive(vecs[i].dv, vecs[i].d, vecs[i].st, vecs[i].sp, vecs[i].dr);
            step();
            check($sformatf("vec%0d", i), vecs[i].e_min, vecs[i].e_tens, vecs[i].e_ones,
                  vecs[i].e_run, vecs[i].e_done);
        end

        // Remaining 9 seconds: done lands 44 cycles after the start edge.
        wait_done(cyc);
        check_int("done_cycle", cyc, 36);
        check("done_pulse", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        step();
        check("done_one_cycle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // 1:00 borrows to 0:59.
        do_reset();
        enter(4'd1);
        enter(4'd0);
        enter(4'd0);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        repeat (4) step();
        check("borrow_min", 4'd0, 4'd5, 4'd9, 1'b1, 1'b0);

        // Door opened at prescaler 2 pauses; resume finishes the partial second.
        do_reset();
        enter(4'd3);
        enter(4'd0);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("door_pause", 4'd0, 4'd3, 4'd0, 1'b0, 1'b0);
        repeat (3) step();
        check("pause_hold", 4'd0, 4'd3, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        step();
        check("resume", 4'd0, 4'd3, 4'd0, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("resume_presc3", 4'd0, 4'd3, 4'd0, 1'b1, 1'b0);
        step();
        check("resume_dec", 4'd0, 4'd2, 4'd9, 1'b1, 1'b0);

        // Stop pauses, second stop clears; zero-time start ignored.
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        step();
        check("stop_pause", 4'd0, 4'd2, 4'd9, 1'b0, 1'b0);
        step();
        check("stop_clear", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        step();
        check("zero_start", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Stop and start together in PAUSE go to IDLE with time cleared.
        enter(4'd5);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        step();
        check("run_5", 4'd0, 4'd0, 4'd5, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        step();
        drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        step();
        check("stop_beats_start", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("idle_after_both", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Open door blocks start in IDLE.
        enter(4'd2);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("door_open_start", 4'd0, 4'd0, 4'd2, 1'b0, 1'b0);

        // Asynchronous reset mid-RUN clears outputs between edges.
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        #2 reset = 1'b1;
        #1;
        check("async_reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        step();
        check("post_reset_idle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        enter(4'd8);
        check("post_reset_entry", 4'd0, 4'd0, 4'd8, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
